// File: rtl/huffman_param_if.sv
// ============================================================================
// Module      : huffman_param_if
// Description : Sample handshake and result bus bundle for huffman_param.
//               master = sample source / result consumer, slave = encoder.
//   gray_valid/gray_data/gray_ready : sample ready/valid handshake
//   cnt_valid/cnt_bus               : per-symbol counts of the frame
//   code_valid/hc_bus/m_bus         : per-symbol codes and length masks
//   sym_err                         : frame contained an out-of-range symbol
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface huffman_param_if #(
  parameter int NSYM   = 6,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8,
  parameter int SYM_W  = 3
);
  logic                     gray_valid;
  logic [SYM_W-1:0]         gray_data;
  logic                     gray_ready;
  logic                     cnt_valid;
  logic [NSYM*CNT_W-1:0]    cnt_bus;
  logic                     code_valid;
  logic [NSYM*CODE_W-1:0]   hc_bus;
  logic [NSYM*CODE_W-1:0]   m_bus;
  logic                     sym_err;

  modport master (
    output gray_valid, gray_data,
    input  gray_ready, cnt_valid, cnt_bus, code_valid, hc_bus, m_bus, sym_err
  );

  modport slave (
    input  gray_valid, gray_data,
    output gray_ready, cnt_valid, cnt_bus, code_valid, hc_bus, m_bus, sym_err
  );
endinterface

`default_nettype wire

// File: rtl/huffman_param.sv
// ============================================================================
// Module      : huffman_param
// Description : Counts a frame of SAMPLES symbols over an NSYM alphabet, then
//               builds a deterministic Huffman code for the frame, one merge
//               per clock. Results are held until the next frame starts.
// Ports       : clk   - clock
//               reset - asynchronous, active-high reset
//               bus   - huffman_param_if.slave (handshake + result buses)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module huffman_param #(
  parameter int NSYM    = 6,
  parameter int SAMPLES = 100,
  parameter int CNT_W   = 8,
  parameter int CODE_W  = 8,
  parameter int SYM_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  huffman_param_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SAMPLES - 1);
  localparam logic [SYM_W-1:0] LAST_STEP = SYM_W'(NSYM - 1);
  localparam logic [SYM_W:0]   NSYM_X    = (SYM_W + 1)'(NSYM);

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_BUILD = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt  [NSYM];
  logic [CODE_W-1:0] hc   [NSYM];
  logic [CODE_W-1:0] msk  [NSYM];
  logic [CNT_W:0]    wt   [NSYM];   // group weight, valid at the group label
  logic [SYM_W-1:0]  grp  [NSYM];   // group label = smallest member index
  logic [CNT_W-1:0]  sample_cnt;
  logic [SYM_W-1:0]  step;          // 0 = init groups, 1..NSYM-1 = merges
  logic              sym_err;

  logic xfer;
  logic last_sample;
  logic bad_sym;
  int   a_idx, b_idx, merged_idx;
  logic a_ok, b_ok;

  assign xfer    = bus.gray_valid & bus.gray_ready;
  assign bad_sym = ({1'b0, bus.gray_data} >= NSYM_X);

  // A transfer in DONE is the first sample of a new frame.
  assign last_sample = (state == S_DONE) ? (SAMPLES == 1) : (sample_cnt == LAST_IDX);

  // Pick the two lowest-ranked groups. A group is live when its label points
  // at itself. The ascending scan with <= lets a later (larger-index) group
  // win a weight tie, which is exactly "larger smallest-member ranks lower".
  always_comb begin
    a_idx = 0;
    b_idx = 0;
    a_ok  = 1'b0;
    b_ok  = 1'b0;
    for (int s = 0; s < NSYM; s++) begin
      if (grp[s] == SYM_W'(s)) begin
        if (!a_ok || wt[s] <= wt[a_idx]) begin
          a_idx = s;
          a_ok  = 1'b1;
        end
      end
    end
    for (int s = 0; s < NSYM; s++) begin
      if (grp[s] == SYM_W'(s) && s != a_idx) begin
        if (!b_ok || wt[s] <= wt[b_idx]) begin
          b_idx = s;
          b_ok  = 1'b1;
        end
      end
    end
    merged_idx = (a_idx < b_idx) ? a_idx : b_idx;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_COUNT;
    else       state <= state_nxt;
  end

  // Next state and handshake/valid outputs
  always_comb begin
    state_nxt      = state;
    bus.gray_ready = 1'b1;
    bus.cnt_valid  = 1'b0;
    bus.code_valid = 1'b0;
    case (state)
      S_COUNT: begin
        if (xfer && last_sample) state_nxt = S_BUILD;
      end
      S_BUILD: begin
        bus.gray_ready = 1'b0;
        bus.cnt_valid  = 1'b1;
        if (step == LAST_STEP) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.cnt_valid  = 1'b1;
        bus.code_valid = 1'b1;
        if (xfer) state_nxt = last_sample ? S_BUILD : S_COUNT;
      end
      default: state_nxt = S_COUNT;
    endcase
  end

  // Datapath: counting, group init and merges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
      step       <= '0;
      sym_err    <= 1'b0;
      for (int s = 0; s < NSYM; s++) begin
        cnt[s] <= '0;
        hc[s]  <= '0;
        msk[s] <= '0;
        wt[s]  <= '0;
        grp[s] <= '0;
      end
    end else begin
      case (state)
        S_COUNT: begin
          if (xfer) begin
            sample_cnt <= last_sample ? '0 : sample_cnt + CNT_W'(1);
            step       <= '0;
            if (bad_sym) sym_err <= 1'b1;
            for (int s = 0; s < NSYM; s++)
              cnt[s] <= cnt[s] + CNT_W'(bus.gray_data == SYM_W'(s));
          end
        end
        S_BUILD: begin
          if (step == '0) begin
            for (int s = 0; s < NSYM; s++) begin
              grp[s] <= SYM_W'(s);
              wt[s]  <= {1'b0, cnt[s]};
            end
          end else begin
            // msk+1 is the one-hot at the member's current length, so OR-ing
            // it in writes bit 1 there; B members keep the 0 already present.
            for (int s = 0; s < NSYM; s++) begin
              if (grp[s] == SYM_W'(a_idx)) begin
                hc[s]  <= hc[s] | (msk[s] + CODE_W'(1));
                msk[s] <= (msk[s] << 1) | CODE_W'(1);
                grp[s] <= SYM_W'(merged_idx);
              end else if (grp[s] == SYM_W'(b_idx)) begin
                msk[s] <= (msk[s] << 1) | CODE_W'(1);
                grp[s] <= SYM_W'(merged_idx);
              end
            end
            wt[merged_idx] <= wt[a_idx] + wt[b_idx];
          end
          step <= step + SYM_W'(1);
        end
        S_DONE: begin
          if (xfer) begin
            sample_cnt <= (SAMPLES == 1) ? '0 : CNT_W'(1);
            step       <= '0;
            sym_err    <= bad_sym;
            for (int s = 0; s < NSYM; s++) begin
              cnt[s] <= CNT_W'(bus.gray_data == SYM_W'(s));
              hc[s]  <= '0;
              msk[s] <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sym_err = sym_err;

  for (genvar g = 0; g < NSYM; g++) begin : g_pack
    assign bus.cnt_bus[g*CNT_W +: CNT_W]  = cnt[g];
    assign bus.hc_bus[g*CODE_W +: CODE_W] = hc[g];
    assign bus.m_bus[g*CODE_W +: CODE_W]  = msk[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_huffman_param.sv
// ============================================================================
// Module      : tb_huffman_param
// Description : Directed self-checking bench for huffman_param. One instance
//               with the default 6-symbol/100-sample configuration and one
//               with a 2-symbol/10-sample configuration.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_huffman_param;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  huffman_param_if #(.NSYM(6), .CNT_W(8), .CODE_W(8), .SYM_W(3)) ifa ();
  huffman_param_if #(.NSYM(2), .CNT_W(8), .CODE_W(8), .SYM_W(3)) ifb ();

  huffman_param #(.NSYM(6), .SAMPLES(100), .CNT_W(8), .CODE_W(8), .SYM_W(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  huffman_param #(.NSYM(2), .SAMPLES(10), .CNT_W(8), .CODE_W(8), .SYM_W(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed expectations (symbol 5 in the top byte)
  localparam logic [47:0] C1_CNT  = 48'h050A0A0F1428;
  localparam logic [47:0] C1_HC   = 48'h050403010001;
  localparam logic [47:0] C1_M    = 48'h0F0F07070701;
  localparam logic [47:0] C2_CNT  = 48'h000000640000;
  localparam logic [47:0] C2_HC   = 48'h1F1E0E000602;
  localparam logic [47:0] C2_M    = 48'h1F1F0F010703;
  localparam logic [47:0] C3_CNT  = 48'h050A0A0F1425;

  int c1 [6] = '{40, 20, 15, 10, 10, 5};
  int c2 [6] = '{0, 0, 100, 0, 0, 0};
  int c3 [6] = '{37, 20, 15, 10, 10, 5};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [2:0] sym);
    @(negedge clk);
    ifa.gray_valid = 1'b1;
    ifa.gray_data  = sym;
    @(posedge clk);
    #1;
    ifa.gray_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] sym);
    @(negedge clk);
    ifb.gray_valid = 1'b1;
    ifb.gray_data  = sym;
    @(posedge clk);
    #1;
    ifb.gray_valid = 1'b0;
  endtask

  // Round-robin interleave (highest symbol first) with nbad symbol-7
  // samples spread over the first rounds.
  task automatic frame_a(input int c [6], input int nbad);
    int rem [6];
    int bad;
    bit any;
    rem = c;
    bad = nbad;
    for (int r = 0; r < 200; r++) begin
      any = 1'b0;
      if (bad > 0) begin
        send_a(3'd7);
        bad--;
        any = 1'b1;
      end
      for (int s = 5; s >= 0; s--) begin
        if (rem[s] > 0) begin
          send_a(3'(s));
          rem[s]--;
          any = 1'b1;
        end
      end
      if (!any) break;
    end
  endtask

  task automatic wait_code_a(input string tag);
    int n;
    n = 0;
    while (!ifa.code_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(ifa.code_valid), 64'd1);
  endtask

  task automatic wait_code_b(input string tag);
    int n;
    n = 0;
    while (!ifb.code_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(ifb.code_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat_b;
    int n;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    ifa.gray_valid = 1'b0;
    ifa.gray_data  = '0;
    ifb.gray_valid = 1'b0;
    ifb.gray_data  = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready",   64'(ifa.gray_ready), 64'd1);
    check("rst_cntv",    64'(ifa.cnt_valid),  64'd0);
    check("rst_codev",   64'(ifa.code_valid), 64'd0);
    check("rst_symerr",  64'(ifa.sym_err),    64'd0);
    check("rst_cnt",     64'(ifa.cnt_bus),    64'd0);
    check("rst_hc",      64'(ifa.hc_bus),     64'd0);
    check("rst_m",       64'(ifa.m_bus),      64'd0);
    reset = 1'b0;

    // Case 1: skewed distribution
    frame_a(c1, 0);
    @(negedge clk);
    check("c1_cntv",     64'(ifa.cnt_valid),  64'd1);
    check("c1_ready_lo", 64'(ifa.gray_ready), 64'd0);
    check("c1_cnt",      64'(ifa.cnt_bus),    64'(C1_CNT));
    wait_code_a("c1_code_in_time");
    check("c1_hc",       64'(ifa.hc_bus),     64'(C1_HC));
    check("c1_m",        64'(ifa.m_bus),      64'(C1_M));
    check("c1_ready_hi", 64'(ifa.gray_ready), 64'd1);
    check("c1_symerr",   64'(ifa.sym_err),    64'd0);

    // Case 3: frame with out-of-range symbols, then a clean frame (case 2)
    frame_a(c3, 3);
    @(negedge clk);
    check("c3_cnt",      64'(ifa.cnt_bus),    64'(C3_CNT));
    check("c3_symerr",   64'(ifa.sym_err),    64'd1);
    wait_code_a("c3_code_in_time");
    check("c3_hc",       64'(ifa.hc_bus),     64'(C1_HC));
    check("c3_m",        64'(ifa.m_bus),      64'(C1_M));
    check("c3_symerr_hold", 64'(ifa.sym_err), 64'd1);
    send_a(3'd2);
    check("c3f2_cntv_drop",  64'(ifa.cnt_valid),  64'd0);
    check("c3f2_codev_drop", 64'(ifa.code_valid), 64'd0);
    check("c3f2_symerr_clr", 64'(ifa.sym_err),    64'd0);
    check("c3f2_cnt_first",  64'(ifa.cnt_bus),    64'h000000010000);
    check("c3f2_hc_clr",     64'(ifa.hc_bus),     64'd0);
    check("c3f2_m_clr",      64'(ifa.m_bus),      64'd0);
    repeat (99) send_a(3'd2);
    @(negedge clk);
    check("c2_cnt",      64'(ifa.cnt_bus),    64'(C2_CNT));
    wait_code_a("c2_code_in_time");
    check("c2_hc",       64'(ifa.hc_bus),     64'(C2_HC));
    check("c2_m",        64'(ifa.m_bus),      64'(C2_M));

    // Case 4: valid held high with garbage throughout BUILD
    frame_a(c1, 0);
    @(negedge clk);
    ifa.gray_valid = 1'b1;
    n = 0;
    while (!ifa.code_valid && n < 60) begin
      check("c4_ready_lo", 64'(ifa.gray_ready), 64'd0);
      check("c4_cnt_hold", 64'(ifa.cnt_bus),    64'(C1_CNT));
      ifa.gray_data = 3'($urandom_range(0, 7));
      @(negedge clk);
      n++;
    end
    ifa.gray_valid = 1'b0;
    check("c4_code_in_time", 64'(ifa.code_valid), 64'd1);
    @(negedge clk);
    check("c4_cnt",      64'(ifa.cnt_bus),    64'(C1_CNT));
    check("c4_hc",       64'(ifa.hc_bus),     64'(C1_HC));
    check("c4_m",        64'(ifa.m_bus),      64'(C1_M));

    // Case 5: reset during BUILD
    frame_a(c1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("c5_mid_build", 64'(ifa.gray_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("c5_rst_ready",  64'(ifa.gray_ready), 64'd1);
    check("c5_rst_cntv",   64'(ifa.cnt_valid),  64'd0);
    check("c5_rst_codev",  64'(ifa.code_valid), 64'd0);
    check("c5_rst_cnt",    64'(ifa.cnt_bus),    64'd0);
    check("c5_rst_hc",     64'(ifa.hc_bus),     64'd0);
    check("c5_rst_m",      64'(ifa.m_bus),      64'd0);
    @(negedge clk);
    reset = 1'b0;
    frame_a(c1, 0);
    @(negedge clk);
    wait_code_a("c5_code_in_time");
    check("c5_hc",       64'(ifa.hc_bus),     64'(C1_HC));
    check("c5_m",        64'(ifa.m_bus),      64'(C1_M));

    // Case 6: two-symbol alphabet, counts 7/3
    pat_b = 10'b0010010010;
    for (int i = 0; i < 10; i++) send_b({2'b00, pat_b[i]});
    @(negedge clk);
    check("c6_cntv",     64'(ifb.cnt_valid),  64'd1);
    check("c6_cnt",      64'(ifb.cnt_bus),    64'h0307);
    wait_code_b("c6_code_in_time");
    check("c6_hc",       64'(ifb.hc_bus),     64'h0100);
    check("c6_m",        64'(ifb.m_bus),      64'h0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
